avalon_alu_array: RTL and testbench
===================================

# avalon_alu_array

Parametrised successor to the HPS-driven PIO adder. It is an Avalon-MM slave holding NUM_CH independent operand/result channels and sharing one pipelined signed add/sub/accumulate datapath between them. A round-robin arbiter issues channel commands into that datapath. Completion is reported per channel through sticky status bits and a maskable interrupt. The block sits on the HPS lightweight bridge and replaces separate a/b/returnvalue PIOs plus fabric adder.

## Interface
- DATA_W, 32: operand/result width (2..32; readdata zero-extends)
- NUM_CH, 4: number of channels (1..7)
- PIPE_STAGES, 2: datapath register stages (1..4)
- ADDR_W, 5: word address width; NUM_CH*4+2 <= 2**ADDR_W
- clk_clk  in  1  single clock
- reset_reset  in  1  asynchronous, active-high reset
- avs_address  in  ADDR_W  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, fixed read latency 1
- irq  out  1  level interrupt, |(irq_status & irq_enable)

## Operation
- Channel c is at word base 4c:
  - +0 A (RW)
  - +1 B (RW)
  - +2 CMD on write / STATUS on read
  - +3 RESULT (RO)
- Address 4*NUM_CH is IRQ_STATUS (bit c per channel, W1C). Address 4*NUM_CH+1 is IRQ_ENABLE (RW). Unmapped reads return 0; unmapped writes are ignored.
- CMD write: op = wd[1:0] (0 ADD: A+B, 1 SUB: A-B, 2 ACC: RESULT+A, 3 CLR: RESULT=0); wd[8] = start. Writes with start=0 do nothing.
- STATUS bits:
  - [0] busy: pending or in flight
  - [1] done: sticky; cleared by RESULT read or new accepted start
  - [2] ovf: signed overflow of last op; CLR gives 0
  - [3] err: sticky; cleared by a CMD write with wd[9]=1
- Start while busy: command dropped, err set.
- Write to A or B while busy: write dropped, err set.
- Arbiter: one issue per cycle among channels with pending=1. Round-robin starting at (last granted + 1) mod NUM_CH. Pointer after reset = NUM_CH-1, so channel 0 is first.
- At issue, the datapath captures op, A, B and the channel's RESULT.
- Arithmetic: two's complement, wraps mod 2^DATA_W. Overflow is set when operand signs are equal (ADD/ACC) or differ (SUB) and the result sign differs from the first operand's sign.
- Retirement: RESULT and ovf written, busy cleared, done set, IRQ_STATUS[c] set.
- IRQ_STATUS same-cycle set and W1C clear: set wins.
- Reset values: every register 0, pipeline valid bits 0, avs_readdata 0, irq 0. Assertion mid-operation flushes in-flight ops with no retirement.

## Timing
- Register writes take effect at the edge where avs_write is sampled.
- avs_readdata is valid the cycle after avs_read and holds until the next read. No waitrequest.
- A RESULT read clears done on the same edge it is sampled. The returned STATUS/RESULT reflect pre-clear values.
- Start accepted at edge t → pending from t. Earliest issue is edge t+1. Retirement is at edge t+1+PIPE_STAGES, so done is readable from cycle t+1+PIPE_STAGES.
- Pipeline accepts one op per cycle. Under contention, channel k waits at most NUM_CH-1 extra cycles.
- Retirement and a same-cycle RESULT read: the read returns the old value; done is set after (set wins).
- irq is registered and rises one cycle after the IRQ_STATUS bit sets.

## Test plan
- Reset then read all addresses → all 0; irq=0.
- Ch0 A=7, B=5, ADD start (wd=0x100) → busy=1 at t+1; STATUS=0x2 and RESULT=12 at t+1+PIPE_STAGES. Then SUB gives RESULT=2.
- Ch1 A=0x7FFFFFFF, B=1, ADD → RESULT=0x80000000, ovf=1. Then ACC with A=1 → 0x80000001, ovf=0. Then CLR → 0, ovf=0.
- Starts on ch0..ch3 in one burst (consecutive write cycles) then idle → issue order 0,1,2,3, retirements in consecutive cycles. IRQ_ENABLE=0xF gives irq=1. W1C 0xF coinciding with a new retirement → that channel's bit stays 1.
- Second start and an A write while ch2 is busy → both dropped, err=1, result unaffected. CMD wd=0x200 clears err.
- reset_reset pulsed one cycle after a start → no done, RESULT=0, irq=0, busy=0.

Source files
------------

// File: rtl/avalon_alu_array.sv
`default_nettype none
// ============================================================================
// Module   : avalon_alu_array
// Brief    : Avalon-MM slave with NUM_CH operand/result channels sharing one
//            pipelined signed add/sub/accumulate datapath. Channels are issued
//            round-robin; completion is flagged through sticky status bits
//            and a maskable level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_alu_array #(
  parameter int DATA_W      = 32,
  parameter int NUM_CH      = 4,
  parameter int PIPE_STAGES = 2,
  parameter int ADDR_W      = 5
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq
);

  localparam int c_ch_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] c_op_add = 2'd0;
  localparam logic [1:0] c_op_sub = 2'd1;
  localparam logic [1:0] c_op_acc = 2'd2;

  localparam logic [1:0] c_reg_a   = 2'd0;
  localparam logic [1:0] c_reg_b   = 2'd1;
  localparam logic [1:0] c_reg_cmd = 2'd2;
  localparam logic [1:0] c_reg_res = 2'd3;

  localparam logic [ADDR_W-1:0] c_addr_irq_status = ADDR_W'(4 * NUM_CH);
  localparam logic [ADDR_W-1:0] c_addr_irq_enable = ADDR_W'(4 * NUM_CH + 1);

  // Per-channel architectural state
  logic [DATA_W-1:0] r_a      [NUM_CH];
  logic [DATA_W-1:0] r_b      [NUM_CH];
  logic [DATA_W-1:0] r_result [NUM_CH];
  logic [1:0]        r_op     [NUM_CH];
  logic [NUM_CH-1:0] r_pending;
  logic [NUM_CH-1:0] r_inflight;
  logic [NUM_CH-1:0] r_done;
  logic [NUM_CH-1:0] r_ovf;
  logic [NUM_CH-1:0] r_err;
  logic [NUM_CH-1:0] r_irq_status;
  logic [NUM_CH-1:0] r_irq_enable;

  // Arbiter and first datapath stage (captured operands)
  logic [c_ch_w-1:0] r_ptr;
  logic              r_s0_valid;
  logic [c_ch_w-1:0] r_s0_ch;
  logic [1:0]        r_s0_op;
  logic [DATA_W-1:0] r_s0_x;
  logic [DATA_W-1:0] r_s0_y;

  logic [DATA_W-1:0] w_s0_res;
  logic              w_s0_ovf;

  // Retirement port from the last pipeline stage
  logic              w_ret_valid;
  logic [c_ch_w-1:0] w_ret_ch;
  logic [DATA_W-1:0] w_ret_res;
  logic              w_ret_ovf;

  logic              w_issue_valid;
  logic [c_ch_w-1:0] w_issue_ch;
  int                w_arb_idx;
  logic [c_ch_w-1:0] w_arb_ch;

  logic              w_ch_valid;
  logic [c_ch_w-1:0] w_addr_ch;
  logic [1:0]        w_addr_reg;
  logic              w_wr_irq_status;
  logic              w_wr_irq_enable;
  logic [NUM_CH-1:0] w_busy;
  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_wr_a;
  logic [NUM_CH-1:0] w_wr_b;
  logic [NUM_CH-1:0] w_wr_cmd;
  logic [NUM_CH-1:0] w_start;
  logic [NUM_CH-1:0] w_rd_res;
  logic [NUM_CH-1:0] w_issue;
  logic [NUM_CH-1:0] w_retire;
  logic [31:0]       w_rdata;

  // Address decode into per-channel strobes plus issue/retire one-hots
  always_comb begin
    w_ch_valid      = int'(avs_address[ADDR_W-1:2]) < NUM_CH;
    w_addr_ch       = avs_address[c_ch_w+1:2];
    w_addr_reg      = avs_address[1:0];
    w_wr_irq_status = avs_write && (avs_address == c_addr_irq_status);
    w_wr_irq_enable = avs_write && (avs_address == c_addr_irq_enable);
    w_busy   = '0;
    w_sel    = '0;
    w_wr_a   = '0;
    w_wr_b   = '0;
    w_wr_cmd = '0;
    w_start  = '0;
    w_rd_res = '0;
    w_issue  = '0;
    w_retire = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_busy[c]   = r_pending[c] | r_inflight[c];
      w_sel[c]    = w_ch_valid && (int'(w_addr_ch) == c);
      w_wr_a[c]   = avs_write && w_sel[c] && (w_addr_reg == c_reg_a);
      w_wr_b[c]   = avs_write && w_sel[c] && (w_addr_reg == c_reg_b);
      w_wr_cmd[c] = avs_write && w_sel[c] && (w_addr_reg == c_reg_cmd);
      w_start[c]  = w_wr_cmd[c] && avs_writedata[8];
      w_rd_res[c] = avs_read && w_sel[c] && (w_addr_reg == c_reg_res);
      w_issue[c]  = w_issue_valid && (int'(w_issue_ch) == c);
      w_retire[c] = w_ret_valid && (int'(w_ret_ch) == c);
    end
  end

  // Round-robin pick: first pending channel after the last one granted
  always_comb begin
    w_issue_valid = 1'b0;
    w_issue_ch    = r_ptr;
    w_arb_idx     = 0;
    w_arb_ch      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_arb_idx = int'(r_ptr) + 1 + i;
      if (w_arb_idx >= NUM_CH) begin
        w_arb_idx = w_arb_idx - NUM_CH;
      end
      w_arb_ch = c_ch_w'(w_arb_idx);
      if (!w_issue_valid && r_pending[w_arb_ch]) begin
        w_issue_valid = 1'b1;
        w_issue_ch    = w_arb_ch;
      end
    end
  end

  // Issue: capture op and operands of the granted channel (ACC uses RESULT+A)
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_ptr      <= c_ch_w'(NUM_CH - 1);
      r_s0_valid <= 1'b0;
      r_s0_ch    <= '0;
      r_s0_op    <= c_op_add;
      r_s0_x     <= '0;
      r_s0_y     <= '0;
    end else begin
      r_s0_valid <= w_issue_valid;
      if (w_issue_valid) begin
        r_ptr   <= w_issue_ch;
        r_s0_ch <= w_issue_ch;
        r_s0_op <= r_op[w_issue_ch];
        if (r_op[w_issue_ch] == c_op_acc) begin
          r_s0_x <= r_result[w_issue_ch];
          r_s0_y <= r_a[w_issue_ch];
        end else begin
          r_s0_x <= r_a[w_issue_ch];
          r_s0_y <= r_b[w_issue_ch];
        end
      end
    end
  end

  // Wrapping signed arithmetic; overflow judged against the first operand's sign
  always_comb begin
    w_s0_res = '0;
    w_s0_ovf = 1'b0;
    case (r_s0_op)
      c_op_add, c_op_acc: begin
        w_s0_res = r_s0_x + r_s0_y;
        w_s0_ovf = (r_s0_x[DATA_W-1] == r_s0_y[DATA_W-1]) &&
                   (w_s0_res[DATA_W-1] != r_s0_x[DATA_W-1]);
      end
      c_op_sub: begin
        w_s0_res = r_s0_x - r_s0_y;
        w_s0_ovf = (r_s0_x[DATA_W-1] != r_s0_y[DATA_W-1]) &&
                   (w_s0_res[DATA_W-1] != r_s0_x[DATA_W-1]);
      end
      default: begin
        w_s0_res = '0;
        w_s0_ovf = 1'b0;
      end
    endcase
  end

  generate
    if (PIPE_STAGES > 1) begin : g_pipe_multi
      localparam int c_n = PIPE_STAGES - 1;
      logic [c_n-1:0]    r_v;
      logic [c_n-1:0]    r_o;
      logic [c_ch_w-1:0] r_c [c_n];
      logic [DATA_W-1:0] r_r [c_n];

      // Carry computed results through the remaining stages
      always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
          r_v <= '0;
          r_o <= '0;
          for (int i = 0; i < c_n; i++) begin
            r_c[i] <= '0;
            r_r[i] <= '0;
          end
        end else begin
          r_v[0] <= r_s0_valid;
          r_o[0] <= w_s0_ovf;
          r_c[0] <= r_s0_ch;
          r_r[0] <= w_s0_res;
          for (int i = 1; i < c_n; i++) begin
            r_v[i] <= r_v[i-1];
            r_o[i] <= r_o[i-1];
            r_c[i] <= r_c[i-1];
            r_r[i] <= r_r[i-1];
          end
        end
      end

      assign w_ret_valid = r_v[c_n-1];
      assign w_ret_ch    = r_c[c_n-1];
      assign w_ret_res   = r_r[c_n-1];
      assign w_ret_ovf   = r_o[c_n-1];
    end else begin : g_pipe_single
      assign w_ret_valid = r_s0_valid;
      assign w_ret_ch    = r_s0_ch;
      assign w_ret_res   = w_s0_res;
      assign w_ret_ovf   = w_s0_ovf;
    end
  endgenerate

  // Channel registers, status flags and interrupt status
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_a[c]      <= '0;
        r_b[c]      <= '0;
        r_result[c] <= '0;
        r_op[c]     <= c_op_add;
      end
      r_pending    <= '0;
      r_inflight   <= '0;
      r_done       <= '0;
      r_ovf        <= '0;
      r_err        <= '0;
      r_irq_status <= '0;
      r_irq_enable <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr_a[c] && !w_busy[c]) begin
          r_a[c] <= avs_writedata[DATA_W-1:0];
        end
        if (w_wr_b[c] && !w_busy[c]) begin
          r_b[c] <= avs_writedata[DATA_W-1:0];
        end
        if (w_start[c] && !w_busy[c]) begin
          r_pending[c] <= 1'b1;
          r_op[c]      <= avs_writedata[1:0];
        end else if (w_issue[c]) begin
          r_pending[c] <= 1'b0;
        end
        if (w_issue[c]) begin
          r_inflight[c] <= 1'b1;
        end else if (w_retire[c]) begin
          r_inflight[c] <= 1'b0;
        end
        if (w_retire[c]) begin
          r_result[c] <= w_ret_res;
          r_ovf[c]    <= w_ret_ovf;
        end
        // Retirement wins over a same-cycle RESULT read
        if (w_retire[c]) begin
          r_done[c] <= 1'b1;
        end else if ((w_start[c] && !w_busy[c]) || w_rd_res[c]) begin
          r_done[c] <= 1'b0;
        end
        // A dropped access sets err even if the same write asks to clear it
        if ((w_wr_a[c] || w_wr_b[c] || w_start[c]) && w_busy[c]) begin
          r_err[c] <= 1'b1;
        end else if (w_wr_cmd[c] && avs_writedata[9]) begin
          r_err[c] <= 1'b0;
        end
        if (w_retire[c]) begin
          r_irq_status[c] <= 1'b1;
        end else if (w_wr_irq_status && avs_writedata[c]) begin
          r_irq_status[c] <= 1'b0;
        end
      end
      if (w_wr_irq_enable) begin
        r_irq_enable <= avs_writedata[NUM_CH-1:0];
      end
    end
  end

  // Read mux over pre-edge register values, zero-extended to the bus
  always_comb begin
    w_rdata = '0;
    if (w_ch_valid) begin
      case (w_addr_reg)
        c_reg_a:   w_rdata = 32'(r_a[w_addr_ch]);
        c_reg_b:   w_rdata = 32'(r_b[w_addr_ch]);
        c_reg_cmd: w_rdata = {28'd0, r_err[w_addr_ch], r_ovf[w_addr_ch],
                              r_done[w_addr_ch], w_busy[w_addr_ch]};
        default:   w_rdata = 32'(r_result[w_addr_ch]);
      endcase
    end else if (avs_address == c_addr_irq_status) begin
      w_rdata = 32'(r_irq_status);
    end else if (avs_address == c_addr_irq_enable) begin
      w_rdata = 32'(r_irq_enable);
    end
  end

  // Registered read data (latency 1, held between reads) and interrupt
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      avs_readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (avs_read) begin
        avs_readdata <= w_rdata;
      end
      irq <= |(r_irq_status & r_irq_enable);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avalon_alu_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_alu_array
// Brief    : Self-checking bench for avalon_alu_array with a behavioural
//            reference model of channel arithmetic, status and interrupts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_alu_array;

  localparam int DATA_W      = 32;
  localparam int NUM_CH      = 4;
  localparam int PIPE_STAGES = 2;
  localparam int ADDR_W      = 5;
  localparam int A_IRQ_ST    = 4 * NUM_CH;
  localparam int A_IRQ_EN    = 4 * NUM_CH + 1;

  logic              clk_clk;
  logic              reset_reset;
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              irq;

  avalon_alu_array #(
    .DATA_W      (DATA_W),
    .NUM_CH      (NUM_CH),
    .PIPE_STAGES (PIPE_STAGES),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .irq           (irq)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  // Edge counter used to reason about latencies
  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ma   [NUM_CH];
  logic [31:0] mb   [NUM_CH];
  logic [31:0] mres [NUM_CH];
  logic        movf [NUM_CH];
  logic        merr [NUM_CH];
  logic [31:0] mirq_st;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input logic [31:0] d);
    avs_address   = ADDR_W'(addr);
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge clk_clk); #1;
    avs_write     = 1'b0;
  endtask

  task automatic rd(input int addr, output logic [31:0] d);
    avs_address = ADDR_W'(addr);
    avs_read    = 1'b1;
    @(posedge clk_clk); #1;
    avs_read    = 1'b0;
    d = avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_clk); #1;
    end
  endtask

  // Plain-integer arithmetic: overflow means the true sum leaves the 32-bit signed range
  task automatic ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, output logic [31:0] res, output logic ovf);
    longint sa, sb, sr, sum;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sr = longint'($signed(r));
    case (op)
      2'd0:    sum = sa + sb;
      2'd1:    sum = sa - sb;
      2'd2:    sum = sr + sa;
      default: sum = 0;
    endcase
    res = sum[31:0];
    ovf = (sum > 64'sd2147483647) || (sum < -64'sd2147483648);
  endtask

  function automatic logic [31:0] status_word(input logic err, input logic ovf,
                                              input logic done, input logic busy);
    return {28'd0, err, ovf, done, busy};
  endfunction

  // Load operands, start, and check busy/done timing, result and done clearing
  task automatic run_op(input int ch, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] d;
    logic [31:0] nres;
    logic        novf;
    wr(4*ch, a);     ma[ch] = a;
    wr(4*ch+1, b);   mb[ch] = b;
    wr(4*ch+2, 32'h100 | 32'(op));
    for (int i = 0; i <= PIPE_STAGES; i++) begin
      rd(4*ch+2, d);
      check($sformatf("busy_ch%0d_t+%0d", ch, i+1), d,
            status_word(merr[ch], movf[ch], 1'b0, 1'b1));
    end
    ref_op(op, ma[ch], mb[ch], mres[ch], nres, novf);
    mres[ch] = nres;
    movf[ch] = novf;
    mirq_st[ch] = 1'b1;
    rd(4*ch+2, d);
    check($sformatf("done_ch%0d_op%0d", ch, op), d, status_word(merr[ch], novf, 1'b1, 1'b0));
    rd(4*ch+3, d);
    check($sformatf("result_ch%0d_op%0d", ch, op), d, nres);
    rd(4*ch+2, d);
    check($sformatf("doneclr_ch%0d", ch), d, status_word(merr[ch], novf, 1'b0, 1'b0));
  endtask

  // Channels started on consecutive edges from t0 retire at t0+c+1+PIPE_STAGES
  function automatic logic [31:0] burst_mask(input int t0, input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((t0 + c + 1 + PIPE_STAGES >= lo) && (t0 + c + 1 + PIPE_STAGES < hi)) m[c] = 1'b1;
    end
    return m;
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    int          ch;
    int          t0;
    int          tw;

    for (int c = 0; c < NUM_CH; c++) begin
      ma[c] = '0; mb[c] = '0; mres[c] = '0; movf[c] = 1'b0; merr[c] = 1'b0;
    end
    mirq_st       = '0;
    reset_reset   = 1'b1;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    #22;
    reset_reset = 1'b0;
    @(posedge clk_clk); #1;

    // Reset state
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      rd(i, d);
      check($sformatf("rst_addr%0d", i), d, 32'd0);
    end

    // Basic ADD then SUB on channel 0
    run_op(0, 2'd0, 32'd7, 32'd5);
    run_op(0, 2'd1, 32'd7, 32'd5);

    // Overflow, accumulate and clear on channel 1
    run_op(1, 2'd0, 32'h7FFF_FFFF, 32'd1);
    run_op(1, 2'd2, 32'd1, 32'd1);
    run_op(1, 2'd3, 32'd3, 32'd4);

    // Randomized operations with occasional extreme operands
    for (int it = 0; it < 10; it++) begin
      ch = int'($urandom_range(0, NUM_CH-1));
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) b = 32'h8000_0000;
      run_op(ch, op, a, b);
    end

    // Interrupt status, enable and W1C
    rd(A_IRQ_ST, d);
    check("irq_status_accum", d, mirq_st);
    check("irq_masked_off", {31'd0, irq}, 32'd0);
    wr(A_IRQ_EN, 32'hF);
    idle(1);
    check("irq_enabled", {31'd0, irq}, {31'd0, |mirq_st[NUM_CH-1:0]});
    rd(A_IRQ_EN, d);
    check("irq_enable_rb", d, 32'hF);
    wr(A_IRQ_ST, 32'hF);
    mirq_st = '0;
    idle(1);
    rd(A_IRQ_ST, d);
    check("irq_status_w1c", d, 32'd0);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);

    // Burst of starts on consecutive cycles; W1C lands on the last retirement
    for (int c = 0; c < NUM_CH; c++) begin
      wr(4*c, 32'(c*3+1));  ma[c] = 32'(c*3+1);
      wr(4*c+1, 32'd100);   mb[c] = 32'd100;
    end
    wr(2, 32'h100);
    t0 = cyc;
    for (int c = 1; c < NUM_CH; c++) wr(4*c+2, 32'h100);
    for (int k = 1; k <= PIPE_STAGES; k++) begin
      rd(A_IRQ_ST, d);
      check($sformatf("burst_irq_st_k%0d", k), d, burst_mask(t0, 0, cyc));
    end
    wr(A_IRQ_ST, 32'hF);
    tw = cyc;
    rd(A_IRQ_ST, d);
    check("burst_w1c_vs_retire", d, burst_mask(t0, tw, cyc));
    check("burst_irq", {31'd0, irq}, 32'd1);
    for (int c = 0; c < NUM_CH; c++) begin
      ref_op(2'd0, ma[c], mb[c], mres[c], mres[c], movf[c]);
      rd(4*c+3, d);
      check($sformatf("burst_result_ch%0d", c), d, mres[c]);
    end
    wr(A_IRQ_ST, 32'hF);
    idle(2);
    check("burst_irq_clear", {31'd0, irq}, 32'd0);

    // Accesses while busy on channel 2 are dropped and flag err
    wr(8, 32'd100);   ma[2] = 32'd100;
    wr(9, 32'd23);    mb[2] = 32'd23;
    wr(10, 32'h100);
    wr(10, 32'h101);
    wr(8, 32'd5);
    merr[2] = 1'b1;
    ref_op(2'd0, ma[2], mb[2], mres[2], mres[2], movf[2]);
    idle(PIPE_STAGES + 1);
    rd(10, d);
    check("busy_drop_status", d, status_word(merr[2], movf[2], 1'b1, 1'b0));
    rd(11, d);
    check("busy_drop_result", d, mres[2]);
    rd(8, d);
    check("busy_drop_a", d, ma[2]);
    wr(10, 32'h200);
    merr[2] = 1'b0;
    rd(10, d);
    check("err_clear", d, status_word(merr[2], movf[2], 1'b0, 1'b0));

    // Reset pulsed while an operation is in flight
    wr(0, 32'd9);
    wr(2, 32'h100);
    @(posedge clk_clk); #1;
    reset_reset = 1'b1;
    #4;
    reset_reset = 1'b0;
    idle(PIPE_STAGES + 3);
    check("rst_mid_irq", {31'd0, irq}, 32'd0);
    rd(2, d);
    check("rst_mid_status", d, 32'd0);
    rd(3, d);
    check("rst_mid_result", d, 32'd0);
    rd(A_IRQ_ST, d);
    check("rst_mid_irq_status", d, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
